// File: rtl/spi_xfer_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_xfer_ctrl
// SPI master transfer controller, mode 0 (CPOL=0, CPHA=0). One START request
// in IDLE runs one DATA_W-bit transaction: CS_N low, a half-period of setup,
// 2*DATA_W SCLK half-periods shifting MOSI out MSB-first and MISO in, a
// half-period of hold, then CS_N high with a one-cycle DONE pulse.
// The SCLK divider only runs while a transaction is in progress.
//
// Ports
//   CLK_I    in   system clock, all logic on posedge
//   RST      in   asynchronous active-low reset
//   START    in   transaction request, sampled only in IDLE
//   DIV      in   SCLK half-period = DIV+1 CLK_I cycles, latched at accept
//   TX_DATA  in   word to send, latched at accept
//   MISO     in   serial input
//   BUSY     out  high from accept until transaction end
//   DONE     out  one-cycle pulse at transaction end
//   RX_DATA  out  last received word, updated only with DONE
//   SCLK     out  SPI clock, idle low
//   MOSI     out  serial output
//   CS_N     out  chip select, active-low
// -----------------------------------------------------------------------------
module spi_xfer_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 4
) (
  input  logic              CLK_I,
  input  logic              RST,
  input  logic              START,
  input  logic [DIV_W-1:0]  DIV,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              MISO,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS_N
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = $clog2(EDGES);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EW-1:0]       edge_q, edge_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tick;
  logic                last_edge;

  assign tick      = (cnt_q == div_q);
  assign last_edge = (edge_q == EW'(EDGES - 1));

  // Next-state and output logic. All outputs are registered, so there is no
  // combinational path from START to the pins. State only ever changes on a
  // tick (or from IDLE, where the counter is parked at 0), so resetting the
  // counter on a tick also clears it on every state change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    div_d     = div_q;
    edge_d    = edge_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (START) begin
          tx_sr_d = TX_DATA;
          div_d   = DIV;
          edge_d  = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = TX_DATA[DATA_W-1];
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (tick) state_d = XFER;
      end

      XFER: begin
        if (tick) begin
          edge_d = edge_q + 1'b1;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[DATA_W-2:0], MISO};
          end else begin
            sclk_d = 1'b0;
            // The final falling edge leaves MOSI on the last bit.
            if (last_edge) begin
              state_d = HOLD;
            end else begin
              mosi_d  = tx_sr_q[DATA_W-2];
              tx_sr_d = tx_sr_q << 1;
            end
          end
        end
      end

      HOLD: begin
        if (tick) begin
          state_d   = IDLE;
          cs_n_d    = 1'b1;
          sclk_d    = 1'b0;
          mosi_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      edge_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign RX_DATA = rx_data_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign CS_N    = cs_n_q;

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

SPI master transfer controller for the SPI interface. It sequences one mode-0 SPI transaction per START request: it asserts chip select and generates SCLK from an internal programmable divider. It shifts TX data out MSB-first and shifts MISO into RX data, then reports completion. It sits between the host-side register logic and the SPI pins, and replaces ad-hoc use of a free-running divided clock with a divider that runs only during a transaction.

## Interface
- DATA_W, 8, bits per transaction
- DIV_W, 4, width of divider setting
- CLK_I  in  1  system clock. Single clock domain; all logic on posedge.
- RST  in  1  reset, asynchronous, active-low
- START  in  1  transaction request. Sampled only in IDLE.
- DIV  in  DIV_W  SCLK half-period = DIV+1 CLK_I cycles. Latched at accept.
- TX_DATA  in  DATA_W  data to send. Latched at accept.
- MISO  in  1  serial input
- BUSY  out  1  high from accept until transaction end
- DONE  out  1  one-cycle pulse at transaction end
- RX_DATA  out  DATA_W  last received word. Updated only at DONE.
- SCLK  out  1  SPI clock, idle low (CPOL=0, CPHA=0)
- MOSI  out  1  serial output
- CS_N  out  1  chip select, active-low

## Operation
- Reset values:
  - CS_N=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0.
  - State is IDLE; tick counter and shift registers are 0.
- Tick counter:
  - Counts 0..div_r.
  - Tick = counter==div_r; the counter returns to 0 on a tick.
  - The counter clears on every state change.
  - All state actions below happen on tick edges only.
- States:
  - IDLE:
    - Outputs are at their reset values, except RX_DATA holds its value and DONE may pulse.
    - START=1 → latch TX_DATA into tx_sr and DIV into div_r.
    - Same edge: CS_N=0, BUSY=1, MOSI=TX_DATA[DATA_W-1]; go to SETUP.
  - SETUP: one half-period with CS_N low and SCLK low. On tick → XFER.
  - XFER: each tick toggles SCLK, for 2*DATA_W ticks in total.
    - Rising edge (SCLK 0→1): rx_sr <= {rx_sr[DATA_W-2:0], MISO}, using the MISO value present at that CLK_I edge.
    - Falling edge (SCLK 1→0), falling edges 1..DATA_W-1: MOSI <= next tx bit.
    - Falling edge DATA_W: no shift, MOSI holds, go to HOLD with SCLK=0.
  - HOLD: one half-period with CS_N still low. On tick → IDLE, and on the same edge:
    - CS_N=1, SCLK=0, MOSI=0, BUSY=0;
    - DONE=1 for exactly one cycle;
    - RX_DATA <= rx_sr.
- Boundary rules:
  - START while BUSY is ignored; there is no queuing.
  - START high in the DONE cycle is accepted, because the state is already IDLE. CS_N is then high for exactly one cycle between transactions.
  - DIV and TX_DATA changes after accept have no effect on the running transaction.
  - RST low at any point: all outputs go immediately (asynchronously) to reset values, and no DONE is produced. After release, the block is in IDLE.
  - div_r=0 is legal: SCLK period is 2 CLK_I cycles. div_r=2^DIV_W-1 gives the longest half-period.

## Timing
- Let D = latched DIV and k = the accept edge.
- Edge k: CS_N falls, BUSY rises, first MOSI bit is valid.
- Edge k+(D+1): SETUP→XFER.
- SCLK rising edges at k+(2i+2)(D+1), for i=0..DATA_W-1.
- SCLK falling edges at k+(2i+3)(D+1), for i=0..DATA_W-1.
- Edge k+(2*DATA_W+2)(D+1): end of HOLD. CS_N=1, BUSY=0, DONE=1, RX_DATA valid.
- Total length for DATA_W=8: 18*(D+1) cycles.
  - D=0 → 18.
  - D=3 → 72.
- SCLK duty cycle is exactly 50%.
- MOSI changes only on SCLK falling edges and at accept, so it is stable at every SCLK rising edge.
- Latency from START to CS_N low: 0 cycles after the sampling edge. There is no output combinational path from START.

## Test plan
- Loopback, DIV=0, TX_DATA=0xA5, MISO=MOSI:
  - DONE exactly 18 cycles after accept; RX_DATA=0xA5;
  - 8 SCLK pulses, each high 1 cycle;
  - CS_N low for 18 cycles.
- DIV=3, TX_DATA=0x3C, MISO tied 1:
  - SCLK high/low 4 cycles each;
  - MOSI bit sequence 0,0,1,1,1,1,0,0 at the rising edges;
  - RX_DATA=0xFF; DONE at cycle 72.
- START pulsed at cycles 5 and 40 of a D=1 transaction (length 36):
  - The second START is ignored;
  - exactly one DONE pulse; BUSY is continuous 36 cycles.
- START held high continuously, D=0:
  - Back-to-back transactions; CS_N high exactly 1 cycle between them;
  - DONE pulses at cycles 18 and 37 after the first accept.
- RST asserted low during XFER, after the 3rd SCLK rise:
  - Outputs go to reset values immediately, with RX_DATA=0 and no DONE;
  - after release, a new START runs a full correct transaction.
- DIV changed from 1 to 7 and TX_DATA changed mid-transfer:
  - Timing stays at D=1 (DONE at cycle 36);
  - shifted-out data equals the originally latched TX_DATA.
